// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX skid buffer: state encoding, entry control record, ALU func codes.
// Forwarding/snoop is built only when ID_EX_FORWARDING_EN is defined.
package id_ex_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Non-datapath fields of one buffered instruction; datapath words live beside it.
  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  func3;
    logic [F7_W-1:0]  func7;
    logic             reg_write;
    logic             imm_sel;
  } entry_ctrl_t;

  localparam logic [F3_W-1:0] FUNC3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] FUNC3_SR   = 3'b101;
  localparam logic [F7_W-1:0] FUNC7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] FUNC7_SUB  = 7'b0100000;
  localparam logic [F7_W-1:0] FUNC7_SRA  = 7'b0100000;

  // A producer matches a source register only if it writes, names it, and it is not x0.
  function automatic logic fwd_hit(input logic we, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return we && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Per-operand forwarding select: MEM result beats WB result beats register file.
// Pass-through unless ID_EX_FORWARDING_EN is defined.
module id_ex_fwd_mux
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [REG_W-1:0]      rs,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic                  mem_we,
  input  logic [REG_W-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wb_we,
  input  logic [REG_W-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] data_c
);

`ifdef ID_EX_FORWARDING_EN
  always_comb begin
    data_c = rs_data;
    if (fwd_hit(mem_we, mem_rd, rs)) begin
      data_c = mem_data;
    end else if (fwd_hit(wb_we, wb_rd, rs)) begin
      data_c = wb_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
  assign data_c     = rs_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register as a 2-entry skid buffer; outputs always come from the head slot (slot 0).
// Define ID_EX_FORWARDING_EN to enable capture forwarding and WB snooping of buffered entries.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic [REG_W-1:0]      id_rd,
  input  logic [F3_W-1:0]       id_func3,
  input  logic [F7_W-1:0]       id_func7,
  input  logic                  id_alu_src_imm,
  input  logic                  id_reg_write,
  input  logic                  mem_fwd_we,
  input  logic                  wb_fwd_we,
  input  logic [REG_W-1:0]      mem_fwd_rd,
  input  logic [REG_W-1:0]      wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [F3_W-1:0]       alu_func3,
  output logic [F7_W-1:0]       alu_func7,
  output logic [REG_W-1:0]      ex_rd,
  output logic                  ex_reg_write
);

  state_e state_q, state_d;
  logic   in_fire, out_fire;
  logic   ld_head, ld_tail, shift;

  logic [DATA_WIDTH-1:0] op1_q [2];
  logic [DATA_WIDTH-1:0] op2_q [2];
  logic [DATA_WIDTH-1:0] pc_q  [2];
  entry_ctrl_t           ctrl_q [2];

  logic [DATA_WIDTH-1:0] hold_op1 [2];
  logic [DATA_WIDTH-1:0] hold_op2 [2];

  logic [DATA_WIDTH-1:0] fwd1_c, fwd2_c, new_op2;
  entry_ctrl_t           new_ctrl;

  // Capture-time operand selection.
  id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
    .rs      (id_rs1),
    .rs_data (id_rs1_data),
    .mem_we  (mem_fwd_we),
    .mem_rd  (mem_fwd_rd),
    .mem_data(mem_fwd_data),
    .wb_we   (wb_fwd_we),
    .wb_rd   (wb_fwd_rd),
    .wb_data (wb_fwd_data),
    .data_c  (fwd1_c)
  );

  id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
    .rs      (id_rs2),
    .rs_data (id_rs2_data),
    .mem_we  (mem_fwd_we),
    .mem_rd  (mem_fwd_rd),
    .mem_data(mem_fwd_data),
    .wb_we   (wb_fwd_we),
    .wb_rd   (wb_fwd_rd),
    .wb_data (wb_fwd_data),
    .data_c  (fwd2_c)
  );

  assign new_op2 = id_alu_src_imm ? id_imm : fwd2_c;

  always_comb begin
    new_ctrl           = '0;
    new_ctrl.rs1       = id_rs1;
    new_ctrl.rs2       = id_rs2;
    new_ctrl.rd        = id_rd;
    new_ctrl.func3     = id_func3;
    new_ctrl.func7     = id_func7;
    new_ctrl.reg_write = id_reg_write;
    new_ctrl.imm_sel   = id_alu_src_imm;
  end

`ifdef ID_EX_FORWARDING_EN
  // Buffered entries pick up a late WB result for their register operands; immediates are left alone.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_op1[i] = op1_q[i];
      hold_op2[i] = op2_q[i];
      if (fwd_hit(wb_fwd_we, wb_fwd_rd, ctrl_q[i].rs1)) begin
        hold_op1[i] = wb_fwd_data;
      end
      if (!ctrl_q[i].imm_sel && fwd_hit(wb_fwd_we, wb_fwd_rd, ctrl_q[i].rs2)) begin
        hold_op2[i] = wb_fwd_data;
      end
    end
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^{ctrl_q[0].rs1, ctrl_q[0].rs2, ctrl_q[0].imm_sel,
                          ctrl_q[1].rs1, ctrl_q[1].rs2, ctrl_q[1].imm_sel};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_op1[i] = op1_q[i];
      hold_op2[i] = op2_q[i];
    end
  end
`endif

  assign in_fire  = id_valid && id_ready;
  assign out_fire = ex_valid && ex_ready;

  // Next state and slot write enables.
  always_comb begin
    state_d = state_q;
    ld_head = 1'b0;
    ld_tail = 1'b0;
    shift   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            ld_head = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            ld_head = 1'b1;
          end else if (in_fire) begin
            state_d = ST_TWO;
            ld_tail = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            shift   = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      id_ready <= 1'b0;
      ex_valid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        op1_q[i]  <= '0;
        op2_q[i]  <= '0;
        pc_q[i]   <= '0;
        ctrl_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      id_ready <= (state_d != ST_TWO);
      ex_valid <= (state_d != ST_EMPTY);

      if (ld_head) begin
        op1_q[0]  <= fwd1_c;
        op2_q[0]  <= new_op2;
        pc_q[0]   <= id_pc;
        ctrl_q[0] <= new_ctrl;
      end else if (shift) begin
        op1_q[0]  <= hold_op1[1];
        op2_q[0]  <= hold_op2[1];
        pc_q[0]   <= pc_q[1];
        ctrl_q[0] <= ctrl_q[1];
      end else begin
        op1_q[0] <= hold_op1[0];
        op2_q[0] <= hold_op2[0];
      end

      if (ld_tail) begin
        op1_q[1]  <= fwd1_c;
        op2_q[1]  <= new_op2;
        pc_q[1]   <= id_pc;
        ctrl_q[1] <= new_ctrl;
      end else begin
        op1_q[1] <= hold_op1[1];
        op2_q[1] <= hold_op2[1];
      end
    end
  end

  assign alu_in1      = op1_q[0];
  assign alu_in2      = op2_q[0];
  assign ex_pc        = pc_q[0];
  assign alu_func3    = ctrl_q[0].func3;
  assign alu_func7    = ctrl_q[0].func7;
  assign ex_rd        = ctrl_q[0].rd;
  assign ex_reg_write = ctrl_q[0].reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: queue-based reference model checked every cycle plus literal spot checks.
module tb_id_ex_stage;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_ready;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [2:0]    id_func3;
  logic [6:0]    id_func7;
  logic          id_alu_src_imm, id_reg_write;
  logic          mem_fwd_we, wb_fwd_we;
  logic [4:0]    mem_fwd_rd, wb_fwd_rd;
  logic [DW-1:0] mem_fwd_data, wb_fwd_data;
  logic          flush;
  logic          ex_valid, ex_ready;
  logic [DW-1:0] alu_in1, alu_in2, ex_pc;
  logic [2:0]    alu_func3;
  logic [6:0]    alu_func7;
  logic [4:0]    ex_rd;
  logic          ex_reg_write;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_func3(id_func3), .id_func7(id_func7),
    .id_alu_src_imm(id_alu_src_imm), .id_reg_write(id_reg_write),
    .mem_fwd_we(mem_fwd_we), .wb_fwd_we(wb_fwd_we),
    .mem_fwd_rd(mem_fwd_rd), .wb_fwd_rd(wb_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_pc(ex_pc),
    .alu_func3(alu_func3), .alu_func7(alu_func7),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered list of at most two pending instructions.
  typedef struct {
    logic [4:0]    rs1, rs2, rd;
    logic [DW-1:0] op1, op2, pc;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          rw, imm;
  } ent_t;

  ent_t q[$];
  logic m_ready = 1'b0;
  logic do_push, do_pop;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic logic [DW-1:0] pick(input logic [4:0] rs, input logic [DW-1:0] d);
    if (FWD && rs != 0 && mem_fwd_we && mem_fwd_rd == rs) return mem_fwd_data;
    if (FWD && rs != 0 && wb_fwd_we && wb_fwd_rd == rs) return wb_fwd_data;
    return d;
  endfunction

  function automatic ent_t incoming();
    ent_t e;
    e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
    e.op1 = pick(id_rs1, id_rs1_data);
    e.op2 = id_alu_src_imm ? id_imm : pick(id_rs2, id_rs2_data);
    e.pc = id_pc; e.f3 = id_func3; e.f7 = id_func7;
    e.rw = id_reg_write; e.imm = id_alu_src_imm;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ready = 1'b0;
    end else begin
      do_push = id_valid && m_ready;
      do_pop  = (q.size() > 0) && ex_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (FWD && wb_fwd_we && wb_fwd_rd != 0) begin
          foreach (q[i]) begin
            if (q[i].rs1 == wb_fwd_rd) q[i].op1 = wb_fwd_data;
            if (!q[i].imm && q[i].rs2 == wb_fwd_rd) q[i].op2 = wb_fwd_data;
          end
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(incoming());
      end
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ex_valid", DW'(ex_valid), DW'(q.size() > 0));
      check("id_ready", DW'(id_ready), DW'(m_ready));
      if (q.size() > 0) begin
        check("alu_in1", alu_in1, q[0].op1);
        check("alu_in2", alu_in2, q[0].op2);
        check("ex_pc", ex_pc, q[0].pc);
        check("ctrl", DW'({alu_func3, alu_func7, ex_rd, ex_reg_write}),
              DW'({q[0].f3, q[0].f7, q[0].rd, q[0].rw}));
      end
    end
  end

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [DW-1:0] d1,
                        input logic [4:0] r2, input logic [DW-1:0] d2,
                        input logic [DW-1:0] imm, input logic si, input logic [DW-1:0] pc);
    id_valid = v; id_rs1 = r1; id_rs1_data = d1; id_rs2 = r2; id_rs2_data = d2;
    id_imm = imm; id_alu_src_imm = si; id_pc = pc;
    id_rd = pc[8:4]; id_func3 = pc[6:4]; id_func7 = pc[13:7]; id_reg_write = ~pc[4];
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    mem_fwd_we = 1'b0; wb_fwd_we = 1'b0; mem_fwd_rd = '0; wb_fwd_rd = '0;
    mem_fwd_data = '0; wb_fwd_data = '0;
    set_in(1'b0, 5'd0, '0, 5'd0, '0, '0, 1'b0, '0);
    #1;
    check("rst_ex_valid", DW'(ex_valid), DW'(0));
    check("rst_id_ready", DW'(id_ready), DW'(0));
    check("rst_alu_in1", alu_in1, '0);
    check("rst_reg_write", DW'(ex_reg_write), DW'(0));
    #21 rst_n = 1'b1;
    tick();
    check("ready_after_rst", DW'(id_ready), DW'(1));

    // Single accept with immediate operand
    ex_ready = 1'b1;
    set_in(1'b1, 5'd1, 64'd5, 5'd2, 64'd9, 64'd7, 1'b1, 64'h40);
    tick();
    id_valid = 1'b0;
    check("acc_valid", DW'(ex_valid), DW'(1));
    check("acc_in1", alu_in1, 64'd5);
    check("acc_in2", alu_in2, 64'd7);
    tick();

    // Fill both slots, third request must be refused, then drain in order
    ex_ready = 1'b0;
    set_in(1'b1, 5'd1, 64'h1, 5'd2, 64'h2, 64'h0, 1'b0, 64'h100);
    tick();
    set_in(1'b1, 5'd1, 64'h3, 5'd2, 64'h4, 64'h0, 1'b0, 64'h200);
    tick();
    check("full_ready", DW'(id_ready), DW'(0));
    set_in(1'b1, 5'd1, 64'h5, 5'd2, 64'h6, 64'h0, 1'b0, 64'h300);
    tick();
    check("full_head_pc", ex_pc, 64'h100);
    id_valid = 1'b0; ex_ready = 1'b1;
    tick();
    check("drain_pc_b", ex_pc, 64'h200);
    tick();
    check("drain_empty", DW'(ex_valid), DW'(0));

    // Forwarding priority and x0 exclusion
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 64'hAA;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 64'hBB;
    set_in(1'b1, 5'd3, 64'h11, 5'd3, 64'h22, 64'h0, 1'b0, 64'h400);
    tick();
    check("fwd_rs1", alu_in1, FWD ? 64'hAA : 64'h11);
    mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
    set_in(1'b1, 5'd0, 64'h33, 5'd0, 64'h44, 64'h0, 1'b0, 64'h500);
    tick();
    check("x0_rs1", alu_in1, 64'h33);
    id_valid = 1'b0; mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
    tick();

    // WB snoop of a stalled entry
    ex_ready = 1'b0;
    set_in(1'b1, 5'd1, 64'h9, 5'd4, 64'h10, 64'h0, 1'b0, 64'h600);
    tick();
    id_valid = 1'b0;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 64'h55;
    tick();
    wb_fwd_we = 1'b0;
    check("snoop_in2", alu_in2, FWD ? 64'h55 : 64'h10);

    // Flush from TWO overrides a pending request
    set_in(1'b1, 5'd1, 64'h7, 5'd2, 64'h8, 64'h0, 1'b0, 64'h700);
    tick();
    check("two_ready", DW'(id_ready), DW'(0));
    flush = 1'b1;
    set_in(1'b1, 5'd1, 64'h7, 5'd2, 64'h8, 64'h0, 1'b0, 64'h800);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    check("flush_valid", DW'(ex_valid), DW'(0));
    check("flush_ready", DW'(id_ready), DW'(1));
    // Flush beats a same-cycle capture from EMPTY
    flush = 1'b1;
    set_in(1'b1, 5'd1, 64'h7, 5'd2, 64'h8, 64'h0, 1'b0, 64'h900);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    check("flush_capture", DW'(ex_valid), DW'(0));

    // Mixed traffic against the model
    for (int n = 0; n < 80; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom},
             5'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), {$urandom, $urandom});
      ex_ready     = 1'($urandom_range(0, 2) != 0);
      flush        = 1'($urandom_range(0, 15) == 0);
      mem_fwd_we   = 1'($urandom_range(0, 1));
      mem_fwd_rd   = 5'($urandom_range(0, 3));
      mem_fwd_data = {$urandom, $urandom};
      wb_fwd_we    = 1'($urandom_range(0, 1));
      wb_fwd_rd    = 5'($urandom_range(0, 3));
      wb_fwd_data  = {$urandom, $urandom};
      tick();
    end
    flush = 1'b0; mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;

    // Asynchronous reset while an entry is presented
    ex_ready = 1'b0;
    set_in(1'b1, 5'd1, 64'h21, 5'd2, 64'h22, 64'h0, 1'b0, 64'hA00);
    tick();
    id_valid = 1'b0;
    check("pre_rst_valid", DW'(ex_valid), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", DW'(ex_valid), DW'(0));
    check("async_rst_ready", DW'(id_ready), DW'(0));
    check("async_rst_pc", ex_pc, '0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_ready", DW'(id_ready), DW'(1));
    check("post_rst_valid", DW'(ex_valid), DW'(0));
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
